// File: rtl/sum_narrow_sat_pkg.sv
// Package: sum_narrow_sat_pkg
// Purpose: shared defaults and helpers for the sum narrowing / saturating
//          write-back block and its saturating event counter.
// Contents:
//   DEF_IN_WIDTH, DEF_OUT_WIDTH, DEF_SHIFT, DEF_CNT_WIDTH - default parameters
//   round_term(shift) - half-LSB rounding addend for a given right shift
// Configuration: the macro SUM_NARROW_ROUND_EN (see sum_narrow_sat) selects
//   round-half-up; round_term is only needed in that build.
package sum_narrow_sat_pkg;

  localparam int DEF_IN_WIDTH  = 11;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_SHIFT     = 0;
  localparam int DEF_CNT_WIDTH = 16;

  // Half of the output LSB after a right shift by 'shift'; zero when no shift.
  function automatic int round_term(input int shift);
    int r;
    if (shift > 32'sd0) begin
      r = 32'sd1 << (shift - 32'sd1);
    end else begin
      r = 32'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_narrow_sat_sat_counter.sv
// Module: sat_counter
// Purpose: saturating up-counter; counts inc pulses and sticks at all ones.
//          A synchronous clear wins over an increment in the same cycle.
// Ports:
//   clk    in  1           rising-edge clock
//   rst_n  in  1           asynchronous active-low reset
//   inc    in  1           count one event this cycle
//   clr    in  1           synchronous clear to zero
//   count  out CNT_WIDTH   registered event count
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count_r;

  // Counter register: clear first, then increment until saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sum_narrow_sat.sv
// Module: sum_narrow_sat
// Purpose: narrows a wide unsigned dot-product sum back to operand width.
//          Stage 1 right-shifts by SHIFT (optionally rounding half-up),
//          stage 2 saturates to OUT_WIDTH bits and flags clamping.
//          Two-stage valid/ready pipeline, full throughput, no bubbles.
// Configuration: define SUM_NARROW_ROUND_EN to add 2^(SHIFT-1) before the
//          shift (round-half-up); undefined gives plain truncation.
// Ports:
//   clk          in  1          rising-edge clock
//   rst_n        in  1          asynchronous active-low reset
//   in_sum       in  IN_WIDTH   wide unsigned sum
//   in_valid     in  1          in_sum valid
//   in_ready     out 1          input accepted this cycle when in_valid=1
//   out_data     out OUT_WIDTH  narrowed, saturated result
//   out_sat      out 1          out_data was clamped
//   out_valid    out 1          out_data/out_sat valid
//   out_ready    in  1          downstream accepts this cycle
//   clear_count  in  1          synchronous clear of sat_count
//   sat_count    out CNT_WIDTH  saturated results handed off (sticks at max)
module sum_narrow_sat
  import sum_narrow_sat_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] sat_count
);

  // One extra bit so a rounding carry out of the top is never lost.
  localparam int SW = IN_WIDTH + 1;
  localparam logic [SW-1:0] SAT_LIMIT = (SW'(1) << OUT_WIDTH) - SW'(1);
`ifdef SUM_NARROW_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(round_term(SHIFT));
`endif

  logic                 adv1_s;
  logic                 adv2_s;
  logic [SW-1:0]        ext_s;
  logic [SW-1:0]        sh_s;
  logic                 sat_s;
  logic [OUT_WIDTH-1:0] nar_s;

  logic                 s1_valid_r;
  logic [SW-1:0]        s1_sh_r;
  logic                 s2_valid_r;
  logic [OUT_WIDTH-1:0] s2_data_r;
  logic                 s2_sat_r;

  // Each stage moves when its successor is empty or moving.
  assign adv2_s   = !s2_valid_r || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  // Stage 1 arithmetic: scale the incoming sum.
  always_comb begin
    ext_s = {1'b0, in_sum};
`ifdef SUM_NARROW_ROUND_EN
    sh_s  = (ext_s + RND) >> SHIFT;
`else
    sh_s  = ext_s >> SHIFT;
`endif
  end

  // Stage 2 arithmetic: clamp to the output range.
  always_comb begin
    sat_s = (s1_sh_r > SAT_LIMIT);
    if (sat_s) begin
      nar_s = '1;
    end else begin
      nar_s = s1_sh_r[OUT_WIDTH-1:0];
    end
  end

  // Pipeline registers; held stages keep their contents while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sh_r    <= '0;
      s2_valid_r <= 1'b0;
      s2_data_r  <= '0;
      s2_sat_r   <= 1'b0;
    end else begin
      if (adv1_s) begin
        s1_valid_r <= in_valid;
        s1_sh_r    <= sh_s;
      end else begin
        s1_valid_r <= s1_valid_r;
        s1_sh_r    <= s1_sh_r;
      end
      if (adv2_s) begin
        s2_valid_r <= s1_valid_r;
        s2_data_r  <= nar_s;
        s2_sat_r   <= sat_s;
      end else begin
        s2_valid_r <= s2_valid_r;
        s2_data_r  <= s2_data_r;
        s2_sat_r   <= s2_sat_r;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_sat   = s2_sat_r;

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (s2_valid_r && out_ready && s2_sat_r),
    .clr   (clear_count),
    .count (sat_count)
  );

endmodule

// File: tb/tb_sum_narrow_sat.sv
// Testbench for sum_narrow_sat. Three instances share the input side:
//   u0: SHIFT=0, CNT_WIDTH=16   u1: SHIFT=1, CNT_WIDTH=16   u2: SHIFT=0, CNT_WIDTH=2
// Honours SUM_NARROW_ROUND_EN for the rounding-dependent expectation.
module tb_sum_narrow_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] in_sum = 11'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clear_count = 1'b0;

  logic        in_ready0, in_ready1, in_ready2;
  logic [7:0]  out_data0, out_data1, out_data2;
  logic        out_sat0, out_sat1, out_sat2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [15:0] sat_count0, sat_count1;
  logic [1:0]  sat_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_narrow_sat #(.IN_WIDTH(11), .OUT_WIDTH(8), .SHIFT(0), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_sat(out_sat0), .out_valid(out_valid0), .out_ready(out_ready),
    .clear_count(clear_count), .sat_count(sat_count0));

  sum_narrow_sat #(.IN_WIDTH(11), .OUT_WIDTH(8), .SHIFT(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_sat(out_sat1), .out_valid(out_valid1), .out_ready(out_ready),
    .clear_count(clear_count), .sat_count(sat_count1));

  sum_narrow_sat #(.IN_WIDTH(11), .OUT_WIDTH(8), .SHIFT(0), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready2),
    .out_data(out_data2), .out_sat(out_sat2), .out_valid(out_valid2), .out_ready(out_ready),
    .clear_count(clear_count), .sat_count(sat_count2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one input for one cycle, then wait until it reaches the output.
  task automatic send_and_wait(input logic [10:0] v);
    in_sum   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 8'd0 || out_sat0 !== 1'b0 || sat_count0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%0d sat=%b cnt=%0d, required 0 0 0 0",
               out_valid0, out_data0, out_sat0, sat_count0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_empty: in_ready=%b out_valid=%b, required 1 0", in_ready0, out_valid0);
    end
  endtask

  task automatic test_basic();
    logic [10:0] sums [4];
    logic [7:0]  e0d [4];
    logic        e0s [4];
    logic [7:0]  e1d [4];
    logic        e1s [4];
    int c0, c1, c2;
    sums = '{11'd200, 11'd510, 11'd509, 11'd2047};
    e0d  = '{8'd200, 8'd255, 8'd255, 8'd255};
    e0s  = '{1'b0, 1'b1, 1'b1, 1'b1};
`ifdef SUM_NARROW_ROUND_EN
    e1d  = '{8'd100, 8'd255, 8'd255, 8'd255};
`else
    e1d  = '{8'd100, 8'd255, 8'd254, 8'd255};
`endif
    e1s  = '{1'b0, 1'b0, 1'b0, 1'b1};
    c0 = 0; c1 = 0; c2 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_and_wait(sums[i]);
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== e0d[i] || out_sat0 !== e0s[i]) begin
        failures++;
        $display("FAIL basic_shift0[%0d]: valid=%b data=%0d sat=%b, required 1 %0d %b",
                 i, out_valid0, out_data0, out_sat0, e0d[i], e0s[i]);
      end
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== e1d[i] || out_sat1 !== e1s[i]) begin
        failures++;
        $display("FAIL basic_shift1[%0d]: valid=%b data=%0d sat=%b, required 1 %0d %b",
                 i, out_valid1, out_data1, out_sat1, e1d[i], e1s[i]);
      end
      tick();
      if (e0s[i]) c0++;
      if (e1s[i]) c1++;
      if (e0s[i] && c2 < 3) c2++;
      checks++;
      if (out_valid0 !== 1'b0 || sat_count0 !== 16'(c0) || sat_count1 !== 16'(c1) || sat_count2 !== 2'(c2)) begin
        failures++;
        $display("FAIL basic_count[%0d]: valid=%b cnt0=%0d cnt1=%0d cnt2=%0d, required 0 %0d %0d %0d",
                 i, out_valid0, sat_count0, sat_count1, sat_count2, c0, c1, c2);
      end
    end
  endtask

  task automatic test_counter();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (sat_count0 !== 16'd0 || sat_count2 !== 2'd0) begin
      failures++;
      $display("FAIL count_clear: cnt0=%0d cnt2=%0d, required 0 0", sat_count0, sat_count2);
    end
    for (int i = 0; i < 5; i++) begin
      send_and_wait(11'd2047);
      tick();
    end
    checks++;
    if (sat_count0 !== 16'd5 || sat_count2 !== 2'd3) begin
      failures++;
      $display("FAIL count_hold: cnt0=%0d cnt2=%0d, required 5 3", sat_count0, sat_count2);
    end
    send_and_wait(11'd2047);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (sat_count0 !== 16'd0 || sat_count2 !== 2'd0 || out_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL count_clear_prio: cnt0=%0d cnt2=%0d valid=%b, required 0 0 0",
               sat_count0, sat_count2, out_valid0);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_sum = 11'h010; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL bp_ready0: in_ready=%b, required 1", in_ready0);
    end
    tick();
    in_sum = 11'h020;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL bp_ready1: in_ready=%b, required 1", in_ready0);
    end
    tick();
    in_sum = 11'h030;
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin
      failures++; $display("FAIL bp_full: in_ready=%b, required 0", in_ready0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 8'h10 || in_ready0 !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall[%0d]: valid=%b data=%0h in_ready=%b, required 1 10 0",
                 i, out_valid0, out_data0, in_ready0);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready0);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'h20) begin
      failures++; $display("FAIL bp_out1: valid=%b data=%0h, required 1 20", out_valid0, out_data0);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'h30) begin
      failures++; $display("FAIL bp_out2: valid=%b data=%0h, required 1 30", out_valid0, out_data0);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++; $display("FAIL bp_drain: valid=%b, required 0", out_valid0);
    end
  endtask

  task automatic test_full_rate();
    out_ready = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin
        in_sum = 11'(i);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 8'(i - 1) || in_ready0 !== 1'b1) begin
          failures++;
          $display("FAIL full_rate[%0d]: valid=%b data=%0d in_ready=%b, required 1 %0d 1",
                   i - 1, out_valid0, out_data0, in_ready0, i - 1);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_sum = 11'd2047; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || sat_count0 !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%b cnt=%0d, required 1 1", out_valid0, sat_count0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || sat_count0 !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%b cnt=%0d, required 0 0", out_valid0, sat_count0);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin
        failures++; $display("FAIL rstmid_idle[%0d]: valid=%b, required 0", i, out_valid0);
      end
    end
    send_and_wait(11'd7);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd7 || out_sat0 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_next: valid=%b data=%0d sat=%b, required 1 7 0", out_valid0, out_data0, out_sat0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_counter();
    test_backpressure();
    test_full_rate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
